sphere_to_cart_seq: RTL

Parametrised successor to the fixed sin/cos constant-multiplier front end. Converts one (radius, azimuth, elevation, channel) sample to signed Cartesian x/y/z using a quarter-wave sine ROM and a single shared multiplier under FSM control. Sits between the range/angle capture logic and the point-cloud buffer. Uses an en/in_ready input handshake and a rdy/ack output handshake, and carries a channel tag through.

---
 rtl/sphere_to_cart_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sphere_to_cart_seq.sv
// Spherical (radius, azimuth, elevation) to signed Cartesian x/y/z using a quarter-wave
// sine ROM and one shared multiplier. Macro SPH_CART_ROUND_EN selects round-half-up products.
module sphere_to_cart_seq #(
  parameter int R_W      = 16,
  parameter int ANG_W    = 10,
  parameter int COEF_W   = 15,
  parameter int CH_W     = 4,
  parameter     LUT_FILE = "sin_quarter.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              in_ready,
  input  logic [R_W-1:0]    radius,
  input  logic [ANG_W-1:0]  azimuth,
  input  logic [ANG_W-1:0]  elevation,
  input  logic [CH_W-1:0]   ch_in,
  output logic              rdy,
  input  logic              ack,
  output logic [R_W:0]      x,
  output logic [R_W:0]      y,
  output logic [R_W:0]      z,
  output logic [CH_W-1:0]   ch_out,
  output logic [3:0]        dbg_state
);

  localparam int N    = 1 << (ANG_W - 2);
  localparam int IDXW = ANG_W - 1;
  localparam int PW   = R_W + COEF_W + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (COEF_W - 1);

  if ((ANG_W < 4) || ($bits(LUT_FILE) < 8)) begin : g_bad_cfg
    $error("sphere_to_cart_seq: ANG_W must be >= 4 and LUT_FILE must be named");
  end

  // ROM contents are the LUT_FILE table (round(sin(pi/2*k/N)*(2^COEF_W-1))),
  // built at elaboration so the block needs no external memory image.
  function automatic logic [COEF_W-1:0] sin_entry(input int k);
    real ang, term, acc;
    ang  = 1.5707963267948966 * k / N;
    term = ang;
    acc  = ang;
    for (int n = 1; n < 14; n++) begin
      term = -term * ang * ang / ((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return COEF_W'($rtoi(acc * ((2.0 ** COEF_W) - 1.0) + 0.5));
  endfunction

  logic [COEF_W-1:0] lut [N+1];
  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam logic [COEF_W-1:0] ENTRY = sin_entry(k);
    assign lut[k] = ENTRY;
  end

  typedef enum logic [3:0] {
    IDLE, RD_CEL, MUL_CEL, RD_SEL, MUL_SEL, RD_CAZ, MUL_CAZ, RD_SAZ, MUL_SAZ, DONE
  } state_t;

  state_t state_q, state_d;

  // Handshakes: a sample is taken on a clk edge with en && in_ready (in_ready only in IDLE);
  // a result is offered with rdy held high and is consumed on a clk edge with rdy && ack.
  assign in_ready  = (state_q == IDLE);
  assign rdy       = (state_q == DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RD_CEL;
      RD_CEL:  state_d = MUL_CEL;
      MUL_CEL: state_d = RD_SEL;
      RD_SEL:  state_d = MUL_SEL;
      MUL_SEL: state_d = RD_CAZ;
      RD_CAZ:  state_d = MUL_CAZ;
      MUL_CAZ: state_d = RD_SAZ;
      RD_SAZ:  state_d = MUL_SAZ;
      MUL_SAZ: state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [R_W-1:0]          radius_q;
  logic [ANG_W-1:0]        az_q, el_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [COEF_W:0]  coef_q;
  logic signed [R_W:0]     rc_q, x_t, z_t;

  logic [ANG_W-1:0]        ang_sel, ang_eff;
  logic                    is_cos;
  logic signed [R_W:0]     mul_a;

  always_comb begin
    ang_sel = az_q;
    is_cos  = 1'b0;
    mul_a   = rc_q;
    case (state_q)
      RD_CEL:           begin ang_sel = el_q; is_cos = 1'b1; end
      RD_SEL:           ang_sel = el_q;
      RD_CAZ:           is_cos = 1'b1;
      MUL_CEL, MUL_SEL: mul_a = $signed({1'b0, radius_q});
      default:          ;
    endcase
  end

  // cos(a) = sin(a + N); the add wraps modulo the full circle.
  logic [1:0]             quad;
  logic [ANG_W-3:0]       low;
  logic [IDXW-1:0]        idx;
  logic signed [COEF_W:0] mag, coef_d;

  assign ang_eff = ang_sel + (is_cos ? ANG_W'(N) : '0);
  assign quad    = ang_eff[ANG_W-1 -: 2];
  assign low     = ang_eff[ANG_W-3:0];
  assign idx     = quad[0] ? (IDXW'(N) - {1'b0, low}) : {1'b0, low};
  assign mag     = $signed({1'b0, lut[idx]});
  assign coef_d  = quad[1] ? -mag : mag;

  logic signed [PW-1:0] prod, prod_r;
  logic signed [R_W:0]  mul_res;

  assign prod = mul_a * coef_q;
`ifdef SPH_CART_ROUND_EN
  assign prod_r = prod + RND;
`else
  assign prod_r = prod;
`endif
  assign mul_res = (R_W+1)'(prod_r >>> COEF_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      radius_q <= '0;
      az_q     <= '0;
      el_q     <= '0;
      ch_q     <= '0;
      coef_q   <= '0;
      rc_q     <= '0;
      x_t      <= '0;
      z_t      <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      ch_out   <= '0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          radius_q <= radius;
          az_q     <= azimuth;
          el_q     <= elevation;
          ch_q     <= ch_in;
        end
        RD_CEL, RD_SEL, RD_CAZ, RD_SAZ: coef_q <= coef_d;
        MUL_CEL: rc_q <= mul_res;
        MUL_SEL: z_t  <= mul_res;
        MUL_CAZ: x_t  <= mul_res;
        MUL_SAZ: begin
          x      <= x_t;
          y      <= mul_res;
          z      <= z_t;
          ch_out <= ch_q;
        end
        default: ;
      endcase
    end
  end

endmodule
